// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIV_U = 2'b01,
    REM_S = 2'b10,
    REM_U = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int unsigned DIV_STEPS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    // A set carry-out bit means shifted >= 2^WIDTH > divisor, so the subtraction always fits.
    fits     = shifted[WIDTH] | ~trial[WIDTH];
    quo_next = {quo[WIDTH-2:0], fits};
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit with start/busy/done handshake.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       DivOpE,
  input  logic [WIDTH-1:0] Op1E,
  input  logic [WIDTH-1:0] Op2E,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] DivResultE
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_n;
  div_op_t          op_e;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             sel_rem_q, neg_q;
  logic             signed_op, accept, special, last;
  logic [WIDTH-1:0] mag1, mag2, special_res, final_val, result_n;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  always_comb begin
    op_e      = div_op_t'(DivOpE);
    signed_op = (op_e == DIV_S) || (op_e == REM_S);
    mag1      = (signed_op && Op1E[WIDTH-1]) ? -Op1E : Op1E;
    mag2      = (signed_op && Op2E[WIDTH-1]) ? -Op2E : Op2E;
    special   = (Op2E == '0) || (signed_op && (Op1E == MIN_NEG) && (Op2E == '1));
    if (Op2E == '0) begin
      special_res = DivOpE[1] ? Op1E : '1;
    end else begin
      special_res = DivOpE[1] ? '0 : MIN_NEG;
    end
    accept    = (state != RUN) && StartE && !FlushE;
    last      = (state == RUN) && (cnt == '0) && !FlushE;
    final_val = sel_rem_q ? rem_n : quo_n;
    result_n  = neg_q ? -final_val : final_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    BusyE   = (state == RUN);
    DoneE   = (state == DONE);
    if (FlushE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (StartE) begin
            state_n = special ? DONE : RUN;
          end else begin
            state_n = IDLE;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state_n = DONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sel_rem_q  <= 1'b0;
      neg_q      <= 1'b0;
      DivResultE <= '0;
    end else if (accept) begin
      if (special) begin
        DivResultE <= special_res;
      end else begin
        rem_q     <= '0;
        quo_q     <= mag1;
        dvs_q     <= mag2;
        cnt       <= 5'(DIV_STEPS - 1);
        sel_rem_q <= DivOpE[1];
        neg_q     <= signed_op && (DivOpE[1] ? Op1E[WIDTH-1] : (Op1E[WIDTH-1] ^ Op2E[WIDTH-1]));
      end
    end else if ((state == RUN) && !FlushE) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt - 5'd1;
      if (last) begin
        DivResultE <= result_n;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences, random ops.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [1:0]  DivOpE;
  logic [31:0] Op1E;
  logic [31:0] Op2E;
  logic        FlushE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] DivResultE;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_exp;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .StartE     (StartE),
    .DivOpE     (DivOpE),
    .Op1E       (Op1E),
    .Op2E       (Op2E),
    .FlushE     (FlushE),
    .BusyE      (BusyE),
    .DoneE      (DoneE),
    .DivResultE (DivResultE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit b2b, input int poke_k,
                        output logic [31:0] res, output int done_k, output bit busy_ok);
    res     = 'x;
    done_k  = -1;
    busy_ok = 1'b1;
    if (!b2b) @(negedge clk);
    StartE = 1'b1;
    DivOpE = op;
    Op1E   = a;
    Op2E   = b;
    @(posedge clk);
    #1 StartE = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == poke_k + 1) StartE = 1'b0;
      if (BusyE !== ((lat == 33) && (k <= 32))) busy_ok = 1'b0;
      if (DoneE === 1'b1) begin
        done_k = k;
        res    = DivResultE;
        break;
      end
      if (k == poke_k) begin
        StartE = 1'b1;
        DivOpE = ~op;
        Op1E   = ~a;
        Op2E   = 32'd3;
      end
    end
    StartE = 1'b0;
  endtask

  task automatic do_check(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit b2b, input int poke_k);
    logic [31:0] res;
    int          done_k;
    bit          busy_ok;
    run_op(op, a, b, lat, b2b, poke_k, res, done_k, busy_ok);
    check({name, "_result"}, res, exp);
    check({name, "_latency"}, 32'(done_k), 32'(lat));
    check({name, "_busy"}, 32'(busy_ok), 32'd1);
    last_exp = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          dones;

    vecs[0]  = '{"divu_100_7",     2'b01, 32'd100,         32'd7,           32'd14,          33};
    vecs[1]  = '{"remu_100_7",     2'b11, 32'd100,         32'd7,           32'd2,           33};
    vecs[2]  = '{"div_m7_2",       2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33};
    vecs[3]  = '{"rem_m7_2",       2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33};
    vecs[4]  = '{"rem_7_m2",       2'b10, 32'd7,           32'hFFFF_FFFE,   32'd1,           33};
    vecs[5]  = '{"div_5_0",        2'b00, 32'd5,           32'd0,           32'hFFFF_FFFF,   1};
    vecs[6]  = '{"remu_5_0",       2'b11, 32'd5,           32'd0,           32'd5,           1};
    vecs[7]  = '{"div_ovf",        2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1};
    vecs[8]  = '{"rem_ovf",        2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1};
    vecs[9]  = '{"divu_max_1",     2'b01, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   33};
    vecs[10] = '{"divu_big_dvs",   2'b01, 32'hFFFF_FFFF,   32'h8000_0001,   32'd1,           33};
    vecs[11] = '{"remu_big_dvs",   2'b11, 32'hFFFF_FFFF,   32'h8000_0001,   32'h7FFF_FFFE,   33};
    vecs[12] = '{"divu_ovf_pat",   2'b01, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           33};
    vecs[13] = '{"div_m100_m7",    2'b00, 32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'd14,          33};

    reset  = 1'b1;
    StartE = 1'b0;
    FlushE = 1'b0;
    DivOpE = 2'b00;
    Op1E   = '0;
    Op2E   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(BusyE), 32'd0);
    check("reset_done", 32'(DoneE), 32'd0);
    check("reset_result", DivResultE, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0, -10);
    end

    // Back-to-back: each new start is driven in the previous op's DONE cycle.
    do_check("b2b_first",  2'b01, 32'd1000, 32'd9, 32'd111, 33, 1'b0, -10);
    do_check("b2b_norm",   2'b11, 32'd1000, 32'd9, 32'd1,   33, 1'b1, -10);
    do_check("b2b_spec",   2'b00, 32'd5,    32'd0, 32'hFFFF_FFFF, 1, 1'b1, -10);
    do_check("b2b_spec2",  2'b11, 32'd5,    32'd0, 32'd5,   1, 1'b1, -10);

    // StartE while busy must not disturb result or latency.
    do_check("start_busy", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, 5);

    // Flush at N+10: no DoneE, result held, then a fresh op completes normally.
    dones = 0;
    @(negedge clk);
    StartE = 1'b1; DivOpE = 2'b01; Op1E = 32'hFFFF_FFFF; Op2E = 32'd1;
    @(posedge clk);
    #1 StartE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (DoneE === 1'b1) dones++;
    end
    FlushE = 1'b1;
    @(posedge clk);
    #1 FlushE = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(BusyE), 32'd0);
    check("flush_done", 32'(DoneE | (dones != 0)), 32'd0);
    check("flush_hold", DivResultE, last_exp);
    do_check("after_flush", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 1'b0, -10);

    // Start and flush in the same cycle: start is dropped.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; DivOpE = 2'b00; Op1E = 32'd9; Op2E = 32'd0;
    @(posedge clk);
    #1 begin StartE = 1'b0; FlushE = 1'b0; end
    @(negedge clk);
    check("flush_start_busy", 32'(BusyE), 32'd0);
    check("flush_start_done", 32'(DoneE), 32'd0);
    check("flush_start_hold", DivResultE, last_exp);

    // Reset in the middle of a running op.
    @(negedge clk);
    StartE = 1'b1; DivOpE = 2'b01; Op1E = 32'd100; Op2E = 32'd7;
    @(posedge clk);
    #1 StartE = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_busy", 32'(BusyE), 32'd0);
    check("midrun_reset_done", 32'(DoneE), 32'd0);
    check("midrun_reset_result", DivResultE, 32'd0);
    repeat (3) @(negedge clk);
    check("midrun_reset_stays_idle", 32'(BusyE | DoneE), 32'd0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       begin a = 32'($urandom_range(0, 200)); b = $urandom; end
        default: b = $urandom;
      endcase
      do_check($sformatf("rand%0d_op%0d_%08h_%08h", i, op, a, b), op, a, b,
               model_res(op, a, b), model_lat(op, a, b), 1'b0, -10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
